// File: rtl/join_key_sched.sv
// Key-join sequencer: buffers one key set, replays it as a probe pass per query
// and reports the per-pass hit count.
module join_key_sched #(
  parameter int KEY_BITS  = 64,
  parameter int MAX_KEYS  = 256,
  parameter int CNT_BITS  = $clog2(MAX_KEYS) + 1,
  parameter int QCNT_BITS = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_key_valid,
  output logic                 s_key_ready,
  input  logic [KEY_BITS-1:0]  s_key_data,
  input  logic                 s_key_last,
  input  logic [QCNT_BITS-1:0] cfg_nqueries,
  input  logic                 cfg_start,
  input  logic                 cfg_clear,
  output logic                 m_probe_valid,
  input  logic                 m_probe_ready,
  output logic [KEY_BITS-1:0]  m_probe_key,
  output logic                 m_probe_last,
  input  logic                 s_hit_valid,
  input  logic                 s_hit,
  output logic                 m_res_valid,
  input  logic                 m_res_ready,
  output logic [CNT_BITS-1:0]  m_res_cnt,
  output logic                 m_res_any,
  output logic [CNT_BITS-1:0]  sts_nkeys,
  output logic                 sts_ovf,
  output logic                 sts_busy,
  output logic                 sts_done
);
  localparam int AW = $clog2(MAX_KEYS);
  localparam logic [CNT_BITS-1:0] ONE    = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] MAX_M1 = CNT_BITS'(MAX_KEYS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SKIP, LOADED, PROBE, DRAIN, RESULT} state_t;
  state_t state, state_nx;

  logic [KEY_BITS-1:0]  mem [MAX_KEYS];
  logic [KEY_BITS-1:0]  rdata;
  logic [CNT_BITS-1:0]  nkeys, pidx, hcnt, rcnt;
  logic [QCNT_BITS-1:0] qleft;
  logic                 ovf, done, pvld;

  logic key_hs, probe_hs, res_hs, storing, hit_beat, last_probe;
  logic [CNT_BITS-1:0] rcnt_nx, pidx_inc;

  assign key_hs     = s_key_valid & s_key_ready;
  assign probe_hs   = m_probe_valid & m_probe_ready;
  assign res_hs     = m_res_valid & m_res_ready;
  assign storing    = key_hs & ((state == IDLE) | (state == LOAD));
  assign hit_beat   = s_hit_valid & ((state == PROBE) | (state == DRAIN));
  assign rcnt_nx    = rcnt + CNT_BITS'(hit_beat);
  assign pidx_inc   = pidx + ONE;
  assign last_probe = (pidx == nkeys - ONE);

  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx      = state;
    s_key_ready   = 1'b0;
    m_probe_valid = 1'b0;
    m_res_valid   = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        s_key_ready = 1'b1;
        if (key_hs) begin
          if (s_key_last)          state_nx = LOADED;
          else if (nkeys == MAX_M1) state_nx = SKIP;
          else                     state_nx = LOAD;
        end
      end
      SKIP: begin
        s_key_ready = 1'b1;
        if (key_hs && s_key_last) state_nx = LOADED;
      end
      LOADED: if (cfg_start && cfg_nqueries != '0) state_nx = PROBE;
      PROBE: begin
        m_probe_valid = pvld;
        if (probe_hs && last_probe) state_nx = DRAIN;
      end
      DRAIN: if (rcnt_nx == nkeys) state_nx = RESULT;
      RESULT: begin
        m_res_valid = 1'b1;
        if (res_hs) state_nx = (qleft == QCNT_BITS'(1)) ? LOADED : PROBE;
      end
      default: state_nx = IDLE;
    endcase
    if (cfg_clear) state_nx = IDLE;
    // handshake outputs are held low for the whole reset window, not just after it
    if (areset) begin
      s_key_ready   = 1'b0;
      m_probe_valid = 1'b0;
      m_res_valid   = 1'b0;
    end
  end

  always_ff @(posedge aclk)
    if (storing) mem[nkeys[AW-1:0]] <= s_key_data;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      nkeys <= '0; pidx <= '0; hcnt <= '0; rcnt <= '0; qleft <= '0;
      ovf <= 1'b0; done <= 1'b0; pvld <= 1'b0; rdata <= '0;
    end else if (cfg_clear) begin
      nkeys <= '0; pidx <= '0; hcnt <= '0; rcnt <= '0; qleft <= '0;
      ovf <= 1'b0; done <= 1'b0; pvld <= 1'b0;
    end else begin
      if (storing) begin
        nkeys <= nkeys + ONE;
        if (!s_key_last && nkeys == MAX_M1) ovf <= 1'b1;
      end
      if (state == LOADED && cfg_start) begin
        if (cfg_nqueries == '0) done <= 1'b1;
        else begin
          qleft <= cfg_nqueries;
          done  <= 1'b0;
        end
      end
      // registered buffer read: prefetch the next key on every accepted probe
      if (state == PROBE) begin
        if (!pvld) begin
          pvld  <= 1'b1;
          rdata <= mem[pidx[AW-1:0]];
        end else if (probe_hs) begin
          pidx <= pidx_inc;
          if (last_probe) pvld <= 1'b0;
          else            rdata <= mem[pidx_inc[AW-1:0]];
        end
      end
      if (hit_beat) begin
        hcnt <= hcnt + CNT_BITS'(s_hit);
        rcnt <= rcnt_nx;
      end
      if (res_hs) begin
        hcnt  <= '0;
        rcnt  <= '0;
        pidx  <= '0;
        qleft <= qleft - QCNT_BITS'(1);
        if (qleft == QCNT_BITS'(1)) done <= 1'b1;
      end
    end
  end

  assign m_probe_key  = rdata;
  assign m_probe_last = m_probe_valid & last_probe;
  assign m_res_cnt    = hcnt;
  assign m_res_any    = (hcnt != '0);
  assign sts_nkeys    = nkeys;
  assign sts_ovf      = ovf;
  assign sts_done     = done;
  assign sts_busy     = (state == PROBE) | (state == DRAIN) | (state == RESULT);
endmodule

// File: tb/tb_join_key_sched.sv
// Bench for join_key_sched: the bench plays the datapath (hit = probe key equals the
// current query value) and checks each pass against counts taken from the key list.
module tb_join_key_sched;
  localparam int KB = 16, MK = 8, CB = 4, QB = 8;

  logic          aclk = 1'b0, areset;
  logic          s_key_valid, s_key_ready, s_key_last;
  logic [KB-1:0] s_key_data;
  logic [QB-1:0] cfg_nqueries;
  logic          cfg_start, cfg_clear;
  logic          m_probe_valid, m_probe_ready, m_probe_last;
  logic [KB-1:0] m_probe_key;
  logic          s_hit_valid, s_hit;
  logic          m_res_valid, m_res_ready, m_res_any;
  logic [CB-1:0] m_res_cnt, sts_nkeys;
  logic          sts_ovf, sts_busy, sts_done;

  join_key_sched #(.KEY_BITS(KB), .MAX_KEYS(MK), .CNT_BITS(CB), .QCNT_BITS(QB)) dut (
    .aclk(aclk), .areset(areset),
    .s_key_valid(s_key_valid), .s_key_ready(s_key_ready), .s_key_data(s_key_data), .s_key_last(s_key_last),
    .cfg_nqueries(cfg_nqueries), .cfg_start(cfg_start), .cfg_clear(cfg_clear),
    .m_probe_valid(m_probe_valid), .m_probe_ready(m_probe_ready), .m_probe_key(m_probe_key), .m_probe_last(m_probe_last),
    .s_hit_valid(s_hit_valid), .s_hit(s_hit),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready), .m_res_cnt(m_res_cnt), .m_res_any(m_res_any),
    .sts_nkeys(sts_nkeys), .sts_ovf(sts_ovf), .sts_busy(sts_busy), .sts_done(sts_done));

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0;
  logic [KB-1:0] src [$];
  logic [KB-1:0] exp_keys [$];
  logic [KB-1:0] qvals [8];
  int nk_exp = 0;
  logic [2:0] hit_lat = 3'd0;
  int rdy_mode = 0;

  // probe ready pattern: 0 = always, 1 = toggle, 2 = random
  always @(negedge aclk)
    case (rdy_mode)
      0:       m_probe_ready = 1'b1;
      1:       m_probe_ready = ~m_probe_ready;
      default: m_probe_ready = 1'($urandom_range(0, 1));
    endcase

  // datapath model: one hit per probe, in order, after hit_lat cycles
  logic       probe_hs, cur_hit;
  logic [7:0] vpipe = '0, bpipe = '0;
  logic [2:0] qidx = '0;
  assign probe_hs    = m_probe_valid && m_probe_ready;
  assign cur_hit     = (m_probe_key == qvals[qidx]);
  assign s_hit_valid = (hit_lat == 3'd0) ? probe_hs : vpipe[hit_lat - 3'd1];
  assign s_hit       = (hit_lat == 3'd0) ? cur_hit  : bpipe[hit_lat - 3'd1];

  always @(posedge aclk) begin
    if (areset || cfg_clear || cfg_start) begin
      vpipe <= '0; bpipe <= '0; qidx <= '0;
    end else begin
      vpipe <= {vpipe[6:0], probe_hs};
      bpipe <= {bpipe[6:0], cur_hit};
      if (probe_hs && m_probe_last) qidx <= qidx + 3'd1;
    end
  end

  // protocol monitor: probe log, stall stability, result-before-last-hit
  logic [KB-1:0] plog_key [$];
  logic          plog_last [$];
  int stall_viol = 0, early = 0, hb = 0;
  logic stall_q = 1'b0, pl_q = 1'b0;
  logic [KB-1:0] pk_q = '0;
  always @(posedge aclk) begin
    if (probe_hs) begin
      plog_key.push_back(m_probe_key);
      plog_last.push_back(m_probe_last);
    end
    if (!areset && stall_q && !(m_probe_valid && m_probe_key == pk_q && m_probe_last == pl_q))
      stall_viol <= stall_viol + 1;
    stall_q <= m_probe_valid && !m_probe_ready && !areset;
    pk_q    <= m_probe_key;
    pl_q    <= m_probe_last;
    if (areset || cfg_clear || cfg_start || (m_res_valid && m_res_ready)) hb <= 0;
    else if (s_hit_valid) hb <= hb + 1;
    if (m_res_valid && hb != nk_exp) early <= early + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    @(negedge aclk);
    cfg_clear = 1'b0;
  endtask

  task automatic load_src();
    int to;
    exp_keys.delete();
    foreach (src[i]) if (i < MK) exp_keys.push_back(src[i]);
    nk_exp = exp_keys.size();
    foreach (src[i]) begin
      s_key_valid = 1'b1;
      s_key_data  = src[i];
      s_key_last  = (i == src.size() - 1);
      to = 0;
      while (!s_key_ready && to < 50) begin @(negedge aclk); to++; end
      if (to >= 50) begin check("key_ready_timeout", 0, 1); break; end
      @(negedge aclk);
      s_key_valid = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge aclk);
    end
    s_key_valid = 1'b0;
    s_key_last  = 1'b0;
    check("nkeys", sts_nkeys, nk_exp);
    check("ovf", sts_ovf, src.size() > MK);
    check("loaded_not_ready", s_key_ready, 0);
  endtask

  task automatic run_pass(input int nq, input int hold);
    int base, sv0, e0, cnt, to, mism, n;
    logic [CB-1:0] held;
    base = plog_key.size(); sv0 = stall_viol; e0 = early;
    cfg_nqueries = QB'(nq);
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    for (int q = 0; q < nq; q++) begin
      to = 0;
      while (!m_res_valid && to < 4000) begin @(negedge aclk); to++; end
      check("res_wait", to < 4000, 1);
      if (to >= 4000) return;
      cnt = 0;
      foreach (exp_keys[i]) if (exp_keys[i] == qvals[q]) cnt++;
      if (hold > 0) begin
        held = m_res_cnt;
        repeat (hold) @(negedge aclk);
        check("res_hold", {m_res_valid, m_res_cnt == held}, 2'b11);
      end
      check("res_cnt", m_res_cnt, cnt);
      check("res_any", m_res_any, cnt != 0);
      m_res_ready = 1'b1;
      @(negedge aclk);
      m_res_ready = 1'b0;
    end
    check("done_idle", {sts_done, sts_busy}, 2'b10);
    n = plog_key.size() - base;
    check("probe_count", n, nq * nk_exp);
    mism = 0;
    for (int i = 0; i < n && nk_exp > 0; i++)
      if (plog_key[base+i] !== exp_keys[i % nk_exp] || plog_last[base+i] !== ((i % nk_exp) == nk_exp - 1))
        mism++;
    check("probe_seq", mism, 0);
    check("stall_stable", stall_viol - sv0, 0);
    check("res_early", early - e0, 0);
  endtask

  initial begin
    int to, b;
    areset = 1'b1; s_key_valid = 1'b0; s_key_data = '0; s_key_last = 1'b0;
    cfg_nqueries = '0; cfg_start = 1'b0; cfg_clear = 1'b0; m_res_ready = 1'b0;
    foreach (qvals[i]) qvals[i] = '0;
    repeat (3) @(negedge aclk);
    check("rst_outs", {s_key_ready, m_probe_valid, m_res_valid, sts_ovf, sts_done, sts_busy}, 0);
    check("rst_nkeys", sts_nkeys, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("idle_ready", s_key_ready, 1);

    // keys {5,9,5}, queries 5 then 9
    src = '{16'd5, 16'd9, 16'd5};
    load_src();
    qvals[0] = 16'd5; qvals[1] = 16'd9;
    run_pass(2, 0);

    // stalled probe stream and a held result
    do_clear();
    check("clear_nkeys", sts_nkeys, 0);
    src = '{16'd1, 16'd2, 16'd1, 16'd3, 16'd1};
    load_src();
    qvals[0] = 16'd1; qvals[1] = 16'd3;
    hit_lat = 3'd2; rdy_mode = 1;
    run_pass(2, 10);

    // overflow: MK+4 keys, last on the final one
    do_clear();
    rdy_mode = 0; hit_lat = 3'd1;
    src.delete();
    for (int i = 0; i < MK + 4; i++) src.push_back(KB'($urandom_range(0, 3)));
    load_src();
    qvals[0] = 16'd2;
    run_pass(1, 0);

    // zero queries
    do_clear();
    src = '{16'd4, 16'd4, 16'd6};
    load_src();
    check("done_before", sts_done, 0);
    b = plog_key.size();
    cfg_nqueries = '0; cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    check("done_zero_q", sts_done, 1);
    repeat (5) @(negedge aclk);
    check("zero_q_probes", plog_key.size() - b, 0);
    check("zero_q_busy", sts_busy, 0);

    // reset in the middle of a pass
    do_clear();
    hit_lat = 3'd0;
    src = '{16'd1, 16'd2, 16'd3, 16'd0};
    load_src();
    b = plog_key.size();
    cfg_nqueries = QB'(1); cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    to = 0;
    while (plog_key.size() - b < 2 && to < 50) begin @(negedge aclk); to++; end
    check("probe_wait", to < 50, 1);
    check("mid_busy", sts_busy, 1);
    areset = 1'b1;
    #1;
    check("arst_outs", {s_key_ready, m_probe_valid, m_res_valid, sts_ovf, sts_done, sts_busy}, 0);
    check("arst_nkeys", sts_nkeys, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    src = '{16'd2, 16'd2, 16'd0};
    load_src();
    qvals[0] = 16'd2;
    run_pass(1, 0);

    // hit latency 0 vs 5, hit pattern 1,0,1,1
    do_clear();
    src = '{16'd7, 16'd3, 16'd7, 16'd7};
    load_src();
    qvals[0] = 16'd7;
    run_pass(1, 0);
    hit_lat = 3'd5;
    run_pass(1, 0);

    // randomized sets, query lists, latencies and back-pressure
    for (int it = 0; it < 15; it++) begin
      do_clear();
      src.delete();
      for (int i = 0, n = $urandom_range(1, MK + 3); i < n; i++) src.push_back(KB'($urandom_range(0, 3)));
      hit_lat  = 3'($urandom_range(0, 5));
      rdy_mode = $urandom_range(0, 2);
      load_src();
      foreach (qvals[i]) qvals[i] = KB'($urandom_range(0, 3));
      run_pass($urandom_range(1, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
